rand_range_draw: RTL and testbench
==================================

Name: rand_range_draw

Overview:
- Consumer of the free-running 31-bit pseudo-random word produced by the game's random generator.
- Converts that word into bounded draws in [0, limit-1] via a req/valid handshake.
- Uses masked rejection sampling with a bounded retry count, so latency is always finite.
- Used by enemy-tank spawn logic (spawn slot, initial direction) and item-drop placement.

Parameters:
- W, 5, width of limit and result (limits up to 2^W).
- OFFSET, 7, LSB index of the W-bit window taken from rnd_in; OFFSET+W-1 <= 30.
- MAX_TRIES, 4, maximum number of samples per draw (>= 1).

Ports:
- Clk  in  1  system clock; rnd_in updates every Clk.
- Reset  in  1  synchronous, active-high reset.
- rnd_in  in  31  current pseudo-random word.
- req  in  1  draw request; sampled only in IDLE.
- limit  in  W  exclusive upper bound; 0 is treated as 2^W.
- busy  out  1  high while a draw is in progress (SAMPLE state).
- valid  out  1  one-cycle pulse; value is valid this cycle.
- value  out  W  drawn result; held until the next valid.
- fallback  out  1  high with valid when the result came from the retry-limit path.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, valid=0, value=0, fallback=0, try counter=0.
- Reset mid-draw aborts the draw: no valid pulse, and the request is lost.
- FSM states are IDLE, SAMPLE, DONE.
- IDLE, with req=1 at edge N:
  - Register lim = (limit==0) ? 2^W : limit, using W+1 bits internally.
  - Register mask = smallest 2^k-1 >= lim-1 (mask=0 when lim=1).
  - Clear tries and go to SAMPLE.
- SAMPLE, each cycle:
  - s = rnd_in[OFFSET+W-1:OFFSET] & mask.
  - If s < lim: register value=s, fallback=0, go to DONE.
  - Else, if tries == MAX_TRIES-1: register value = s - lim, fallback=1, go to DONE. The result is guaranteed < lim because s <= mask < 2*lim.
  - Else: tries++, stay in SAMPLE. The next cycle sees a new rnd_in.
- DONE: valid=1 for exactly this cycle, then go to IDLE.
- Latency:
  - Accepted req at edge N gives valid at cycle N+2 on first-sample acceptance.
  - Worst case is N+1+MAX_TRIES.
- busy=1 exactly while in SAMPLE; valid and busy are never both high.
- req during SAMPLE or DONE is ignored (not queued); requester must wait for valid before re-requesting.
- req held high continuously gives back-to-back draws, with one idle cycle per draw (the IDLE accept cycle).
- limit is sampled only at accept; changes during a draw have no effect.
- lim=1 gives mask=0, so s=0 and the draw is accepted at first sample (value=0).
- Power-of-two lim gives mask=lim-1; always accepted at first sample.
- value holds its last result through IDLE and SAMPLE; it changes only at entry to DONE.
- All arithmetic is unsigned.
- tries counter is $clog2(MAX_TRIES)+1 bits wide; no wrap is possible.

Decomposition:
- Shared game package holds:
  - typedef rd_state_t {IDLE, SAMPLE, DONE};
  - constant RAND_WORD_W = 31, shared with the generator.
- One natural sub-module: rand_mask_gen, a purely combinational map from lim-1 to an all-ones mask covering its MSB (priority-OR smear). Instantiate it once.
- Everything else stays in the top module.

Test Plan:
- Reset held 3 cycles mid-SAMPLE (limit=5, rnd window forced 7) -> busy=0, valid=0, value=0 the cycle after Reset; no valid pulse afterward until a new req.
- limit=5, window sequence 6 then 3 -> mask=7:
  - first sample rejected, second accepted;
  - valid at N+3, value=3, fallback=0.
- limit=5, MAX_TRIES=4, window held at 7 -> four rejects; valid at N+5, value=2, fallback=1.
- limit=8, window=13 (masked to 5) -> valid at N+2, value=5.
- limit=1 -> value=0, valid at N+2 regardless of rnd_in.
- limit=0 (treated as 32), window=31 -> value=31.
- req pulsed during SAMPLE with limit changed to 3 -> ignored; result uses original limit 5 and exactly one valid pulse occurs.
- req held high for 3 draws (limit=8) -> valid pulses spaced 3 cycles apart.
- Randomized: 10k draws with limit=6 using the real generator -> every value < 6 and each of 0..5 occurs.

Source files
------------

// File: rtl/rand_range_draw_pkg.sv
// Shared game definitions: draw FSM encoding and the generator word width.
package rand_range_draw_pkg;

   localparam int RAND_WORD_W = 31;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      DONE   = 2'd2
   } rd_state_t;

endpackage

// File: rtl/rand_range_draw_mask_gen.sv
// Combinational smear: every bit at or below the MSB of val_i is set,
// giving the smallest 2^k-1 that is >= val_i.
module rand_mask_gen #(
   parameter int N = 6
) (
   input  logic [N-1:0] val_i,
   output logic [N-1:0] mask_o
);

   logic [N-1:0] smear_s;

   // Priority-OR from the MSB down.
   always_comb begin
      smear_s = {N{1'b0}};
      smear_s[N-1] = val_i[N-1];
      for (int i = N - 2; i >= 0; i--) begin
         smear_s[i] = smear_s[i+1] | val_i[i];
      end
   end

   assign mask_o = smear_s;

endmodule

// File: rtl/rand_range_draw.sv
// Bounded random draw in [0, limit-1] from the free-running generator word,
// using masked rejection sampling with a fixed retry budget.
module rand_range_draw
   import rand_range_draw_pkg::*;
#(
   parameter int W         = 5,
   parameter int OFFSET    = 7,
   parameter int MAX_TRIES = 4
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [RAND_WORD_W-1:0] rnd_in,
   input  logic                   req,
   input  logic [W-1:0]           limit,
   output logic                   busy,
   output logic                   valid,
   output logic [W-1:0]           value,
   output logic                   fallback
);

   localparam int TW = $clog2(MAX_TRIES) + 1;
   localparam logic [TW-1:0] LAST_TRY   = TW'(MAX_TRIES - 1);
   localparam logic [TW-1:0] TRY_ONE    = {{(TW-1){1'b0}}, 1'b1};
   localparam logic [W:0]    FULL_RANGE = {1'b1, {W{1'b0}}};
   localparam logic [W:0]    ONE_W1     = {{W{1'b0}}, 1'b1};

   rd_state_t       state_q, state_d;
   logic [W:0]      lim_q, lim_d;
   logic [W:0]      mask_q, mask_d;
   logic [TW-1:0]   tries_q, tries_d;
   logic [W-1:0]    value_q, value_d;
   logic            fallback_q, fallback_d;
   logic            busy_q, busy_d;
   logic            valid_q, valid_d;

   logic [W:0]      lim_acc_s;
   logic [W:0]      lim_acc_m1_s;
   logic [W:0]      mask_acc_s;
   logic [W-1:0]    window_s;
   logic [W:0]      sample_s;
   logic [W:0]      diff_s;
   logic            unused_s;

   // A zero limit selects the full 2^W range, hence the extra bit.
   assign lim_acc_s    = (limit == {W{1'b0}}) ? FULL_RANGE : {1'b0, limit};
   assign lim_acc_m1_s = lim_acc_s - ONE_W1;

   rand_mask_gen #(.N(W + 1)) u_mask_gen (
      .val_i  (lim_acc_m1_s),
      .mask_o (mask_acc_s)
   );

   assign window_s = rnd_in[OFFSET+W-1:OFFSET];
   assign sample_s = {1'b0, window_s} & mask_q;
   // sample <= mask < 2*lim, so the reduced value always fits below lim.
   assign diff_s   = sample_s - lim_q;
   assign unused_s = ^{rnd_in[RAND_WORD_W-1:OFFSET+W], rnd_in[OFFSET-1:0], diff_s[W]};

   // Next-state and datapath update for the draw FSM.
   always_comb begin
      state_d    = state_q;
      lim_d      = lim_q;
      mask_d     = mask_q;
      tries_d    = tries_q;
      value_d    = value_q;
      fallback_d = fallback_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               lim_d   = lim_acc_s;
               mask_d  = mask_acc_s;
               tries_d = {TW{1'b0}};
               state_d = SAMPLE;
            end else begin
               state_d = IDLE;
            end
         end
         SAMPLE: begin
            if (sample_s < lim_q) begin
               value_d    = sample_s[W-1:0];
               fallback_d = 1'b0;
               state_d    = DONE;
            end else if (tries_q == LAST_TRY) begin
               value_d    = diff_s[W-1:0];
               fallback_d = 1'b1;
               state_d    = DONE;
            end else begin
               tries_d    = tries_q + TRY_ONE;
               state_d    = SAMPLE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d  = (state_d == SAMPLE);
      valid_d = (state_d == DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         lim_q      <= {(W+1){1'b0}};
         mask_q     <= {(W+1){1'b0}};
         tries_q    <= {TW{1'b0}};
         value_q    <= {W{1'b0}};
         fallback_q <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         lim_q      <= lim_d;
         mask_q     <= mask_d;
         tries_q    <= tries_d;
         value_q    <= value_d;
         fallback_q <= fallback_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
      end
   end

   assign busy     = busy_q;
   assign valid    = valid_q;
   assign value    = value_q;
   assign fallback = fallback_q;

endmodule

// File: tb/tb_rand_range_draw.sv
// Directed bench for rand_range_draw with hand-computed expectations and a
// reference model for the long random-word run.
module tb_rand_range_draw;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [30:0] rnd_in;
   logic        req;
   logic [4:0]  limit;
   logic        busy;
   logic        valid;
   logic [4:0]  value;
   logic        fallback;

   int vectors = 0;
   int miscompares = 0;

   logic [30:0] lfsr;
   logic        rnd_run;

   rand_range_draw dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .rnd_in   (rnd_in),
      .req      (req),
      .limit    (limit),
      .busy     (busy),
      .valid    (valid),
      .value    (value),
      .fallback (fallback)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock; outputs are looked at 1 time unit after the edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         #1;
         if (rnd_run) begin
            lfsr   = {lfsr[29:0], lfsr[30] ^ lfsr[27]};
            rnd_in = lfsr;
         end
      end
   endtask

   // Place a 5-bit window at bits [11:7] with junk in the other bits.
   task automatic set_win(input logic [4:0] w);
      rnd_in = (31'h2A5A_5A5A & ~(31'h0000_001F << 7)) | ({26'd0, w} << 7);
   endtask

   int          pulses;
   int          pos[4];
   int          bad;
   int          oor;
   logic [5:0]  seen;
   logic [4:0]  w;
   logic [4:0]  ev;
   logic        ef;
   logic        done;

   initial begin
      rnd_run = 1'b0;
      lfsr    = 31'h1234_5678;
      Reset   = 1'b1;
      req     = 1'b0;
      limit   = 5'd0;
      set_win(5'd0);
      tick(2);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_value", {27'd0, value}, 32'd0);
      chk("rst_fallback", {31'd0, fallback}, 32'd0);
      Reset = 1'b0;
      tick(1);

      // limit=8, window 13 masked to 5, first-sample accept
      req = 1'b1; limit = 5'd8; set_win(5'd13);
      tick(1);
      req = 1'b0;
      chk("l8_busy", {31'd0, busy}, 32'd1);
      chk("l8_valid_early", {31'd0, valid}, 32'd0);
      tick(1);
      chk("l8_valid", {31'd0, valid}, 32'd1);
      chk("l8_busy_off", {31'd0, busy}, 32'd0);
      chk("l8_value", {27'd0, value}, 32'd5);
      chk("l8_fallback", {31'd0, fallback}, 32'd0);
      tick(1);
      chk("l8_pulse_one_cycle", {31'd0, valid}, 32'd0);

      // reset held three cycles mid-SAMPLE aborts the draw
      req = 1'b1; limit = 5'd5; set_win(5'd7);
      tick(1);
      req = 1'b0;
      tick(1);
      chk("rs_busy_before", {31'd0, busy}, 32'd1);
      Reset = 1'b1;
      tick(1);
      chk("rs_busy", {31'd0, busy}, 32'd0);
      chk("rs_valid", {31'd0, valid}, 32'd0);
      chk("rs_value", {27'd0, value}, 32'd0);
      tick(2);
      Reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (valid === 1'b1 || busy === 1'b1) pulses++;
      end
      chk("rs_no_activity", pulses, 32'd0);

      // limit=5, window 6 then 3: one reject then accept
      req = 1'b1; limit = 5'd5; set_win(5'd6);
      tick(1);
      req = 1'b0;
      tick(1);
      chk("r1_busy", {31'd0, busy}, 32'd1);
      chk("r1_valid_early", {31'd0, valid}, 32'd0);
      chk("r1_value_held", {27'd0, value}, 32'd0);
      set_win(5'd3);
      tick(1);
      chk("r1_valid", {31'd0, valid}, 32'd1);
      chk("r1_value", {27'd0, value}, 32'd3);
      chk("r1_fallback", {31'd0, fallback}, 32'd0);
      tick(1);
      chk("r1_value_hold_idle", {27'd0, value}, 32'd3);

      // limit=5, window stuck at 7: retry budget exhausted, 7-5=2
      req = 1'b1; limit = 5'd5; set_win(5'd7);
      tick(1);
      req = 1'b0;
      tick(3);
      chk("fb_busy_t3", {31'd0, busy}, 32'd1);
      chk("fb_valid_t3", {31'd0, valid}, 32'd0);
      tick(1);
      chk("fb_valid", {31'd0, valid}, 32'd1);
      chk("fb_value", {27'd0, value}, 32'd2);
      chk("fb_fallback", {31'd0, fallback}, 32'd1);
      tick(1);

      // limit=1 always yields 0 at first sample
      req = 1'b1; limit = 5'd1; set_win(5'd31);
      tick(1);
      req = 1'b0;
      tick(1);
      chk("l1_valid", {31'd0, valid}, 32'd1);
      chk("l1_value", {27'd0, value}, 32'd0);
      chk("l1_fallback", {31'd0, fallback}, 32'd0);
      tick(1);

      // limit=0 means 32
      req = 1'b1; limit = 5'd0; set_win(5'd31);
      tick(1);
      req = 1'b0;
      tick(1);
      chk("l0_valid", {31'd0, valid}, 32'd1);
      chk("l0_value", {27'd0, value}, 32'd31);
      tick(1);

      // req and a new limit during SAMPLE are ignored
      req = 1'b1; limit = 5'd5; set_win(5'd6);
      pulses = 0;
      tick(1);
      limit = 5'd3;
      tick(1);
      if (valid === 1'b1) pulses++;
      chk("ig_busy", {31'd0, busy}, 32'd1);
      set_win(5'd4);
      req = 1'b0;
      tick(1);
      if (valid === 1'b1) pulses++;
      chk("ig_value", {27'd0, value}, 32'd4);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         if (valid === 1'b1) pulses++;
      end
      chk("ig_one_pulse", pulses, 32'd1);

      // req held: back-to-back draws with valid every 3 cycles
      req = 1'b1; limit = 5'd8; set_win(5'd2);
      pulses = 0;
      for (int i = 1; i <= 9; i++) begin
         tick(1);
         if (valid === 1'b1) begin
            if (pulses < 4) pos[pulses] = i;
            pulses++;
         end
      end
      req = 1'b0;
      tick(3);
      chk("b2b_count", pulses, 32'd3);
      chk("b2b_first", pos[0], 32'd2);
      chk("b2b_gap1", pos[1] - pos[0], 32'd3);
      chk("b2b_gap2", pos[2] - pos[1], 32'd3);

      // long run on an LFSR word, limit=6 (mask 7), against a reference model
      rnd_run = 1'b1;
      rnd_in  = lfsr;
      bad  = 0;
      oor  = 0;
      seen = 6'd0;
      for (int d = 0; d < 10000; d++) begin
         limit = 5'd6; req = 1'b1;
         tick(1);
         req  = 1'b0;
         done = 1'b0;
         ev   = 5'd0;
         ef   = 1'b0;
         for (int t = 0; t < 4 && !done; t++) begin
            w = rnd_in[11:7] & 5'd7;
            if (w < 5'd6) begin
               ev = w; ef = 1'b0; done = 1'b1;
            end else if (t == 3) begin
               ev = w - 5'd6; ef = 1'b1; done = 1'b1;
            end
            tick(1);
            if (valid !== done) bad++;
            if (done) begin
               if (value !== ev || fallback !== ef) bad++;
               if (value < 5'd6) seen[value[2:0]] = 1'b1;
               else oor++;
            end
         end
         tick(1);
      end
      rnd_run = 1'b0;
      chk("rand_model", bad, 32'd0);
      chk("rand_range", oor, 32'd0);
      chk("rand_cover", {26'd0, seen}, 32'h3F);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
